// File: rtl/vga_timing_pkg.sv
// ============================================================================
// vga_timing_pkg : shared 640x480@60 timing defaults and coordinate width
// Revision 1.0
// ============================================================================
`default_nettype none

package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int DEF_DIV       = 4;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int H_TOTAL  = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL  = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int HS_START = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int HS_END   = HS_START + DEF_H_SYNC - 1;
  localparam int VS_START = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int VS_END   = VS_START + DEF_V_SYNC - 1;

  function automatic logic in_window(input logic [COORD_W-1:0] v,
                                     input logic [COORD_W-1:0] lo,
                                     input logic [COORD_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_scan_gen_pixel_tick_div.sv
// ============================================================================
// pixel_tick_div : divides clk down to a one-cycle pixel-rate pulse
// Revision 1.0
// ============================================================================
`default_nettype none

module pixel_tick_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] C_LAST = W'(DIV - 1);

  logic [W-1:0] div_q;
  logic [W-1:0] div_d;

  always_comb begin
    div_d = (div_q == C_LAST) ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign p_tick = (div_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/vga_scan_gen.sv
// ============================================================================
// vga_scan_gen : VGA raster counters, sync decode and frame strobe
// Revision 1.0
// ============================================================================
`default_nettype none

module vga_scan_gen
  import vga_timing_pkg::*;
#(
  parameter int DIV       = DEF_DIV,
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic               clk,
  input  logic               reset,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               video_on,
  output logic               hsync,
  output logic               vsync,
  output logic               p_tick,
  output logic               frame_tick
);

  localparam int L_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int L_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COORD_W-1:0] C_H_LAST   = COORD_W'(L_H_TOTAL - 1);
  localparam logic [COORD_W-1:0] C_V_LAST   = COORD_W'(L_V_TOTAL - 1);
  localparam logic [COORD_W-1:0] C_H_VIS    = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] C_V_VIS    = COORD_W'(V_VISIBLE);
  localparam logic [COORD_W-1:0] C_HS_START = COORD_W'(H_VISIBLE + H_FRONT);
  localparam logic [COORD_W-1:0] C_HS_END   = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [COORD_W-1:0] C_VS_START = COORD_W'(V_VISIBLE + V_FRONT);
  localparam logic [COORD_W-1:0] C_VS_END   = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic               tick;
  logic [COORD_W-1:0] h_q, h_d;
  logic [COORD_W-1:0] v_q, v_d;
  logic               hsync_q, vsync_q, video_on_q;

  pixel_tick_div #(
    .DIV (DIV)
  ) u_div (
    .clk    (clk),
    .reset  (reset),
    .p_tick (tick)
  );

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (tick) begin
      if (h_q == C_H_LAST) begin
        h_d = '0;
        v_d = (v_q == C_V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Sync/blank decode from next-state counters keeps them aligned with x/y.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q        <= '0;
      v_q        <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      video_on_q <= 1'b1;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      hsync_q    <= !in_window(h_d, C_HS_START, C_HS_END);
      vsync_q    <= !in_window(v_d, C_VS_START, C_VS_END);
      video_on_q <= (h_d < C_H_VIS) && (v_d < C_V_VIS);
    end
  end

  assign x          = h_q;
  assign y          = v_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign video_on   = video_on_q;
  assign p_tick     = tick;
  assign frame_tick = tick && (h_q == C_H_LAST) && (v_q == C_V_LAST);

endmodule

`default_nettype wire

// File: tb/tb_vga_scan_gen.sv
// ============================================================================
// tb_vga_scan_gen : raster model checks on a default and a shrunken instance
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_vga_scan_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Default 640x480 instance
  logic [9:0] d_x, d_y;
  logic d_vo, d_hs, d_vs, d_pt, d_ft;
  vga_scan_gen u_def (
    .clk(clk), .reset(reset), .x(d_x), .y(d_y), .video_on(d_vo),
    .hsync(d_hs), .vsync(d_vs), .p_tick(d_pt), .frame_tick(d_ft)
  );

  // Small raster: 32 x 20 pixels, so whole frames fit in a short run
  localparam int S_DIV = 4, S_HV = 16, S_HF = 4, S_HS = 8, S_HB = 4;
  localparam int S_VV = 12, S_VF = 2, S_VS = 2, S_VB = 4;
  localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VV + S_VF + S_VS + S_VB;
  localparam int S_FRAME = S_HT * S_VT * S_DIV;

  logic [9:0] s_x, s_y;
  logic s_vo, s_hs, s_vs, s_pt, s_ft;
  vga_scan_gen #(
    .DIV(S_DIV), .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
  ) u_sml (
    .clk(clk), .reset(reset), .x(s_x), .y(s_y), .video_on(s_vo),
    .hsync(s_hs), .vsync(s_vs), .p_tick(s_pt), .frame_tick(s_ft)
  );

  // k = clk edges since the last reset edge; the model derives everything from it
  int k = 0;
  bit valid = 1'b0;
  bit run1 = 1'b0;
  always @(posedge clk) begin
    if (reset) begin
      k     <= 0;
      valid <= 1'b1;
    end else begin
      k <= k + 1;
    end
  end

  function automatic logic [24:0] model(input int kk, input int dv, input int hv,
                                        input int hf, input int hs, input int ht,
                                        input int vv, input int vf, input int vs,
                                        input int vt);
    int p, xx, yy;
    logic pt, ft, hsn, vsn, vo;
    p   = kk / dv;
    xx  = p % ht;
    yy  = (p / ht) % vt;
    pt  = ((kk % dv) == dv - 1);
    ft  = pt && (xx == ht - 1) && (yy == vt - 1);
    hsn = !((xx >= hv + hf) && (xx < hv + hf + hs));
    vsn = !((yy >= vv + vf) && (yy < vv + vf + vs));
    vo  = (xx < hv) && (yy < vv);
    return {xx[9:0], yy[9:0], hsn, vsn, vo, pt, ft};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at k=%0d: got %0d expected %0d", name, k, act, exp);
    end
  endtask

  // Per-cycle compare of both instances against the model
  always @(negedge clk) begin
    if (valid) begin
      logic [24:0] ed, es;
      ed = model(k, 4, 640, 16, 96, 800, 480, 10, 2, 525);
      es = model(k, S_DIV, S_HV, S_HF, S_HS, S_HT, S_VV, S_VF, S_VS, S_VT);
      total += 2;
      if ({d_x, d_y, d_hs, d_vs, d_vo, d_pt, d_ft} !== ed) begin
        bad++;
        $display("FAIL def_raster k=%0d got x=%0d y=%0d hs/vs/vo/pt/ft=%b%b%b%b%b expected x=%0d y=%0d %b",
                 k, d_x, d_y, d_hs, d_vs, d_vo, d_pt, d_ft, ed[24:15], ed[14:5], ed[4:0]);
      end
      if ({s_x, s_y, s_hs, s_vs, s_vo, s_pt, s_ft} !== es) begin
        bad++;
        $display("FAIL sml_raster k=%0d got x=%0d y=%0d hs/vs/vo/pt/ft=%b%b%b%b%b expected x=%0d y=%0d %b",
                 k, s_x, s_y, s_hs, s_vs, s_vo, s_pt, s_ft, es[24:15], es[14:5], es[4:0]);
      end
    end
  end

  // Hand-computed landmarks pinning the model on the first run after reset
  int vs_low_cnt = 0;
  int ft_cnt = 0;
  int last_ft_k = -1;
  always @(negedge clk) begin
    if (run1 && !reset) begin
      case (k)
        2:    chk("ptick_c3", int'(d_pt), 0);
        3:    chk("ptick_c4", int'(d_pt), 1);
        4:    begin chk("x_after_tick", int'(d_x), 1); chk("ptick_c5", int'(d_pt), 0); end
        7:    chk("ptick_c8", int'(d_pt), 1);
        11:   chk("ptick_c12", int'(d_pt), 1);
        2559: begin chk("vo_x639", int'(d_vo), 1); chk("sml_ft", int'(s_ft), 1); end
        2560: begin
                chk("x640", int'(d_x), 640); chk("vo_x640", int'(d_vo), 0);
                chk("sml_wrap_x", int'(s_x), 0); chk("sml_wrap_y", int'(s_y), 0);
              end
        2623: chk("hs_x655", int'(d_hs), 1);
        2624: begin chk("x656", int'(d_x), 656); chk("hs_x656", int'(d_hs), 0); end
        3007: chk("hs_x751", int'(d_hs), 0);
        3008: begin chk("x752", int'(d_x), 752); chk("hs_x752", int'(d_hs), 1); end
        3199: begin chk("x799", int'(d_x), 799); chk("y_before_wrap", int'(d_y), 0); end
        3200: begin chk("x_wrap", int'(d_x), 0); chk("y1", int'(d_y), 1); end
        default: ;
      endcase
      if (k < S_FRAME && !s_vs) vs_low_cnt++;
      if (s_ft) begin
        ft_cnt++;
        if (last_ft_k >= 0) chk("ft_spacing", k - last_ft_k, S_FRAME);
        last_ft_k = k;
      end
    end
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_x", int'(d_x), 0);
    chk("rst_y", int'(d_y), 0);
    chk("rst_hs", int'(d_hs), 1);
    chk("rst_vs", int'(d_vs), 1);
    chk("rst_vo", int'(d_vo), 1);
    chk("rst_pt", int'(d_pt), 0);
    chk("rst_ft", int'(s_ft), 0);
    run1  = 1'b1;
    reset = 1'b0;
    repeat (6000) @(negedge clk);
    run1 = 1'b0;
    chk("vs_low_clks", vs_low_cnt, 2 * S_HT * S_DIV);
    chk("ft_count", ft_cnt, 2);

    // Wait for the small raster to sit inside its hsync pulse, then reset there
    begin
      int n = 0;
      while (!(s_x == 10'(S_HV + S_HF + 2) && s_y >= 10'd3) && n < 4000) begin
        @(negedge clk);
        n++;
      end
      chk("mid_wait_timeout", int'(n < 4000), 1);
    end
    chk("pre_reset_hs", int'(s_hs), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_x", int'(s_x), 0);
    chk("mid_rst_y", int'(s_y), 0);
    chk("mid_rst_hs", int'(s_hs), 1);
    chk("mid_rst_def_x", int'(d_x), 0);
    reset = 1'b0;
    repeat (3000) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
